// File: rtl/core_memory_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package core_memory_arbiter_pkg;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_t;

   localparam logic [1:0] ORDER_BYTE = 2'b00;
   localparam logic [1:0] ORDER_HALF = 2'b01;
   localparam logic [1:0] ORDER_WORD = 2'b10;
   localparam logic [3:0] MASK_WORD  = 4'hF;

   typedef struct packed {
      logic [1:0]  order;
      logic [3:0]  mask;
      logic        rw;
      logic [31:0] addr;
      logic [13:0] tid;
      logic [1:0]  mmumod;
      logic [2:0]  ps;
      logic [31:0] pdt;
      logic [31:0] data;
   } mem_req_t;

endpackage

// File: rtl/core_memory_arbiter_tag_fifo.sv
// 1-bit tag FIFO with occupancy count; pushes when full and pops when empty are ignored.
// Zero-latency read of the head entry; no internal backpressure beyond the full/empty guards.
module core_memory_arbiter_tag_fifo #(
   parameter int P_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       din,
   input  logic                       pop,
   output logic                       dout,
   output logic                       empty,
   output logic [$clog2(P_DEPTH):0]   count
);

   localparam int AW = $clog2(P_DEPTH);
   localparam int CW = AW + 1;

   logic [P_DEPTH-1:0] mem_q;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               full;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CW'(P_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr];

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr] <= din;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/core_memory_arbiter.sv
// Shares one memory bus between fetch and data ports; 1-cycle registered request stage, 0-cycle tagged response routing.
// Ports lock when the stage is held, arbitration is lost or reads exceed credit; MIST1032_MEMARB_ROUNDROBIN_EN selects round-robin over DATA priority.
module core_memory_arbiter
   import core_memory_arbiter_pkg::*;
#(
   parameter int P_OUTSTANDING = 4
) (
   input  logic        iCLOCK,
   input  logic        iRESET,
   input  logic        iINST_REQ,
   output logic        oINST_LOCK,
   input  logic [31:0] iINST_ADDR,
   input  logic [13:0] iINST_TID,
   input  logic [1:0]  iINST_MMUMOD,
   input  logic [2:0]  iINST_PS,
   input  logic [31:0] iINST_PDT,
   output logic        oINST_VALID,
   input  logic        iINST_BUSY,
   output logic [63:0] oINST_DATA,
   output logic [23:0] oINST_MMU_FLAGS,
   input  logic        iDATA_REQ,
   output logic        oDATA_LOCK,
   input  logic [1:0]  iDATA_ORDER,
   input  logic [3:0]  iDATA_MASK,
   input  logic        iDATA_RW,
   input  logic [31:0] iDATA_ADDR,
   input  logic [13:0] iDATA_TID,
   input  logic [1:0]  iDATA_MMUMOD,
   input  logic [2:0]  iDATA_PS,
   input  logic [31:0] iDATA_PDT,
   input  logic [31:0] iDATA_DATA,
   output logic        oDATA_VALID,
   output logic [63:0] oDATA_DATA,
   output logic [23:0] oDATA_MMU_FLAGS,
   output logic        oMEM_REQ,
   input  logic        iMEM_LOCK,
   output logic [1:0]  oMEM_ORDER,
   output logic [3:0]  oMEM_MASK,
   output logic        oMEM_RW,
   output logic [31:0] oMEM_ADDR,
   output logic [13:0] oMEM_TID,
   output logic [31:0] oMEM_PDT,
   output logic [1:0]  oMEM_MMUMOD,
   output logic [2:0]  oMEM_PS,
   output logic [31:0] oMEM_DATA,
   input  logic        iMEM_VALID,
   output logic        oMEM_BUSY,
   input  logic [63:0] iMEM_DATA,
   input  logic [23:0] iMEM_MMU_FLAGS,
   output logic        oPROTOCOL_ERR
);

   localparam int CW = $clog2(P_OUTSTANDING) + 1;
   localparam logic [CW-1:0] MAX_INFLIGHT = CW'(P_OUTSTANDING);

   logic          mem_req_q;
   mem_req_t      stage_q;
   mem_req_t      inst_fields;
   mem_req_t      data_fields;
   logic [CW-1:0] inflight;
   logic          tag_head;
   logic          tag_empty;
   logic          tag_push;
   logic          tag_pop;
   logic          tag_din;
   logic          inst_head;
   logic          data_head;
   logic          stage_free;
   logic          credit_ok;
   logic          inst_gnt;
   logic          data_gnt;
   logic          inst_acc;
   logic          data_acc;
   logic          proto_err_q;

   assign stage_free = !mem_req_q || !iMEM_LOCK;
   // Count-based only: a response popping this cycle does not free a credit until next cycle.
   assign credit_ok  = (inflight < MAX_INFLIGHT);

`ifdef MIST1032_MEMARB_ROUNDROBIN_EN
   src_t rr_ptr;

   assign inst_gnt = !iDATA_REQ || (iINST_REQ && rr_ptr == SRC_INST);
   assign data_gnt = !iINST_REQ || (iDATA_REQ && rr_ptr == SRC_DATA);

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         rr_ptr <= SRC_INST;
      end else if (iINST_REQ && iDATA_REQ && (inst_acc || data_acc)) begin
         rr_ptr <= inst_acc ? SRC_DATA : SRC_INST;
      end
   end
`else
   assign inst_gnt = !iDATA_REQ;
   assign data_gnt = 1'b1;
`endif

   assign oINST_LOCK = iRESET || !(stage_free && inst_gnt && credit_ok);
   assign oDATA_LOCK = iRESET || !(stage_free && data_gnt && (!iDATA_RW || credit_ok));
   assign inst_acc   = iINST_REQ && !oINST_LOCK;
   assign data_acc   = iDATA_REQ && !oDATA_LOCK;

   assign inst_fields = '{order: ORDER_WORD, mask: MASK_WORD, rw: 1'b1, addr: iINST_ADDR,
                          tid: iINST_TID, mmumod: iINST_MMUMOD, ps: iINST_PS, pdt: iINST_PDT,
                          data: 32'h0};
   assign data_fields = '{order: iDATA_ORDER, mask: iDATA_MASK, rw: iDATA_RW, addr: iDATA_ADDR,
                          tid: iDATA_TID, mmumod: iDATA_MMUMOD, ps: iDATA_PS, pdt: iDATA_PDT,
                          data: iDATA_DATA};

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         mem_req_q <= 1'b0;
         stage_q   <= '0;
      end else if (inst_acc) begin
         mem_req_q <= 1'b1;
         stage_q   <= inst_fields;
      end else if (data_acc) begin
         mem_req_q <= 1'b1;
         stage_q   <= data_fields;
      end else if (!iMEM_LOCK) begin
         mem_req_q <= 1'b0;
      end
   end

   assign oMEM_REQ    = mem_req_q;
   assign oMEM_ORDER  = stage_q.order;
   assign oMEM_MASK   = stage_q.mask;
   assign oMEM_RW     = stage_q.rw;
   assign oMEM_ADDR   = stage_q.addr;
   assign oMEM_TID    = stage_q.tid;
   assign oMEM_PDT    = stage_q.pdt;
   assign oMEM_MMUMOD = stage_q.mmumod;
   assign oMEM_PS     = stage_q.ps;
   assign oMEM_DATA   = stage_q.data;

   // Only reads earn a tag; writes complete without a response.
   assign tag_push = inst_acc || (data_acc && iDATA_RW);
   assign tag_din  = data_acc;

   core_memory_arbiter_tag_fifo #(
      .P_DEPTH (P_OUTSTANDING)
   ) u_tag_fifo (
      .clk   (iCLOCK),
      .rst   (iRESET),
      .push  (tag_push),
      .din   (tag_din),
      .pop   (tag_pop),
      .dout  (tag_head),
      .empty (tag_empty),
      .count (inflight)
   );

   assign inst_head = !tag_empty && (src_t'(tag_head) == SRC_INST);
   assign data_head = !tag_empty && (src_t'(tag_head) == SRC_DATA);

   assign oINST_VALID     = iMEM_VALID && inst_head;
   assign oDATA_VALID     = iMEM_VALID && data_head;
   assign oINST_DATA      = iMEM_DATA;
   assign oDATA_DATA      = iMEM_DATA;
   assign oINST_MMU_FLAGS = iMEM_MMU_FLAGS;
   assign oDATA_MMU_FLAGS = iMEM_MMU_FLAGS;
   assign oMEM_BUSY       = iINST_BUSY && inst_head;
   assign tag_pop         = iMEM_VALID && !tag_empty && !oMEM_BUSY;

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= iMEM_VALID && tag_empty;
      end
   end

   assign oPROTOCOL_ERR = proto_err_q;

endmodule
